// File: rtl/kalman_pkg.sv
// ---------------------------------------------------------------------------
// kalman_pkg
// Shared definitions for the Kalman filter host slice: Q20.12 word geometry,
// flat matrix bus widths, the host sequencer state type and small helpers
// for clamping the measurement count and slicing a state word out of the
// flat x bus.
// ---------------------------------------------------------------------------
package kalman_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned FRAC_W    = 12;
    localparam int unsigned MAX_STATE = 6;
    localparam int unsigned MAX_MEAS  = 4;

    localparam int unsigned X_FLAT_W = WORD_W * MAX_STATE;              // 192
    localparam int unsigned P_FLAT_W = WORD_W * MAX_STATE * MAX_STATE;  // 1152
    localparam int unsigned Z_FLAT_W = WORD_W * MAX_MEAS;               // 128

    typedef enum logic [1:0] {
        COLLECT,
        START,
        WAIT,
        EMIT
    } host_state_t;

    // A requested measurement count of 0 or above MAX_MEAS means "use all slots".
    function automatic logic [2:0] clamp_meas(input logic [2:0] size);
        if (size == 3'd0 || size > 3'(MAX_MEAS)) begin
            return 3'(MAX_MEAS);
        end
        return size;
    endfunction

    function automatic logic [WORD_W-1:0] x_word(input logic [X_FLAT_W-1:0] v,
                                                 input logic [2:0]          idx);
        return v[32'(idx) * WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/kalman_word_serializer.sv
// ---------------------------------------------------------------------------
// kalman_word_serializer
// Streams the first SIZE_STATE words of a flat state vector out over a
// valid/ready interface, one word per handshake, with index and last flag.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       start a new burst at word 0 (vec sampled this cycle)
//   vec        flat state vector the words are taken from
//   ready      downstream ready
//   valid      word valid (registered)
//   data       current word (registered, held while stalled)
//   idx        index of data within vec
//   last       high on word SIZE_STATE-1
//   done       combinational pulse: handshake on the last word
// ---------------------------------------------------------------------------
module kalman_word_serializer
    import kalman_pkg::*;
#(
    parameter int unsigned SIZE_STATE = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [X_FLAT_W-1:0] vec,
    input  logic                ready,
    output logic                valid,
    output logic [WORD_W-1:0]   data,
    output logic [2:0]          idx,
    output logic                last,
    output logic                done
);

    localparam logic [2:0] LAST_IDX = 3'(SIZE_STATE - 1);

    logic [2:0] idx_next;

    assign idx_next = idx + 3'd1;
    assign done     = valid && ready && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            idx   <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            idx   <= '0;
            data  <= x_word(vec, 3'd0);
            last  <= (LAST_IDX == 3'd0);
        end else if (valid && ready) begin
            if (last) begin
                valid <= 1'b0;
                last  <= 1'b0;
                idx   <= '0;
            end else begin
                idx  <= idx_next;
                data <= x_word(vec, idx_next);
                last <= (idx_next == LAST_IDX);
            end
        end
    end

endmodule

// File: rtl/kalman_stream_host.sv
// ---------------------------------------------------------------------------
// kalman_stream_host
// Initiator-side sequencer for the Kalman filter top. Collects measurement
// words into z_flat, owns the persistent x/P registers, pulses kf_start,
// waits (with watchdog) for kf_done, writes the filter outputs back as the
// next x/P and streams the new state estimate out word by word.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   init, x0_flat, P0_flat   load initial x/P (honoured only in COLLECT)
//   size_meas                measurements per iteration (0 or >4 -> 4)
//   meas_valid/data/ready    measurement input stream
//   kf_start/done            filter handshake
//   kf_x_out, kf_P_out       filter results
//   x_flat, P_flat, z_flat   registered operands driven to the filter
//   est_valid/ready/data/idx/last   estimate output stream
//   busy                     high when not in COLLECT
//   iter_count               completed iterations (wraps)
//   timeout_err              sticky watchdog error
// ---------------------------------------------------------------------------
module kalman_stream_host
    import kalman_pkg::*;
#(
    parameter int unsigned SIZE_STATE = 6,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  logic [X_FLAT_W-1:0] x0_flat,
    input  logic [P_FLAT_W-1:0] P0_flat,
    input  logic [2:0]          size_meas,
    input  logic                meas_valid,
    input  logic [WORD_W-1:0]   meas_data,
    output logic                meas_ready,
    output logic                kf_start,
    input  logic                kf_done,
    input  logic [X_FLAT_W-1:0] kf_x_out,
    input  logic [P_FLAT_W-1:0] kf_P_out,
    output logic [X_FLAT_W-1:0] x_flat,
    output logic [P_FLAT_W-1:0] P_flat,
    output logic [Z_FLAT_W-1:0] z_flat,
    output logic                est_valid,
    input  logic                est_ready,
    output logic [WORD_W-1:0]   est_data,
    output logic [2:0]          est_idx,
    output logic                est_last,
    output logic                busy,
    output logic [15:0]         iter_count,
    output logic                timeout_err
);

    localparam int unsigned    WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    host_state_t         state, state_next;
    logic [2:0]          k;
    logic [2:0]          n_meas;
    logic [2:0]          n_eff;
    logic [WD_W-1:0]     wd;
    logic                accept;
    logic                last_word;
    logic                ser_load;
    logic                ser_done;
    logic [X_FLAT_W-1:0] emit_src;

    // The count is latched on word 0, so word 0 must use the live (clamped) input.
    assign n_eff = (k == 3'd0) ? clamp_meas(size_meas) : n_meas;

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin : next_state_logic
        state_next = state;
        unique case (state)
            COLLECT: if (accept && last_word) state_next = START;
            START:   state_next = WAIT;
            WAIT: begin
                if (kf_done) begin
                    state_next = EMIT;
                end else if (wd == WD_LAST) begin
                    state_next = COLLECT;
                end
            end
            EMIT:    if (ser_done) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_comb begin : output_logic
        meas_ready = (state == COLLECT) && !init;
        accept     = meas_valid && meas_ready;
        last_word  = (k == n_eff - 3'd1);
        ser_load   = (state == WAIT) && kf_done;
    end

    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            x_flat      <= '0;
            P_flat      <= '0;
            z_flat      <= '0;
            k           <= '0;
            n_meas      <= '0;
            wd          <= '0;
            iter_count  <= '0;
            timeout_err <= 1'b0;
            kf_start    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Registered from next state so both line up with the state register.
            kf_start <= (state_next == START);
            busy     <= (state_next != COLLECT);
            unique case (state)
                COLLECT: begin
                    if (init) begin
                        x_flat      <= x0_flat;
                        P_flat      <= P0_flat;
                        z_flat      <= '0;
                        k           <= '0;
                        iter_count  <= '0;
                        timeout_err <= 1'b0;
                    end else if (accept) begin
                        z_flat[32'(k) * WORD_W +: WORD_W] <= meas_data;
                        if (k == 3'd0) begin
                            n_meas <= clamp_meas(size_meas);
                        end
                        if (last_word) begin
                            k <= '0;
                            // Unused slots are zeroed so stale words never reach the filter.
                            for (int unsigned i = 0; i < MAX_MEAS; i++) begin
                                if (i > 32'(k)) begin
                                    z_flat[i * WORD_W +: WORD_W] <= '0;
                                end
                            end
                        end else begin
                            k <= k + 3'd1;
                        end
                    end
                end
                START: wd <= '0;
                WAIT: begin
                    if (kf_done) begin
                        x_flat     <= kf_x_out;
                        P_flat     <= kf_P_out;
                        iter_count <= iter_count + 16'd1;
                    end else if (wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                        k           <= '0;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                EMIT: k <= '0;
                default: ;
            endcase
        end
    end

    // On the load cycle x_flat still holds the old state; take the fresh result.
    assign emit_src = ser_load ? kf_x_out : x_flat;

    kalman_word_serializer #(
        .SIZE_STATE(SIZE_STATE)
    ) u_serializer (
        .clk  (clk),
        .rst  (rst),
        .load (ser_load),
        .vec  (emit_src),
        .ready(est_ready),
        .valid(est_valid),
        .data (est_data),
        .idx  (est_idx),
        .last (est_last),
        .done (ser_done)
    );

endmodule

// File: tb/tb_kalman_stream_host.sv
`timescale 1ns/1ps
module tb_kalman_stream_host;
    import kalman_pkg::*;

    localparam int unsigned NS = 6;
    localparam int unsigned TO = 16;

    logic                clk = 1'b0;
    logic                rst, init, meas_valid, meas_ready, kf_start, kf_done;
    logic [X_FLAT_W-1:0] x0_flat, kf_x_out, x_flat;
    logic [P_FLAT_W-1:0] P0_flat, kf_P_out, P_flat;
    logic [Z_FLAT_W-1:0] z_flat;
    logic [2:0]          size_meas, est_idx;
    logic [31:0]         meas_data, est_data;
    logic                est_valid, est_ready, est_last, busy, timeout_err;
    logic [15:0]         iter_count;

    always #5 clk = ~clk;

    kalman_stream_host #(.SIZE_STATE(NS), .WORD_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .init(init), .x0_flat(x0_flat), .P0_flat(P0_flat),
        .size_meas(size_meas), .meas_valid(meas_valid), .meas_data(meas_data),
        .meas_ready(meas_ready), .kf_start(kf_start), .kf_done(kf_done),
        .kf_x_out(kf_x_out), .kf_P_out(kf_P_out), .x_flat(x_flat), .P_flat(P_flat),
        .z_flat(z_flat), .est_valid(est_valid), .est_ready(est_ready),
        .est_data(est_data), .est_idx(est_idx), .est_last(est_last), .busy(busy),
        .iter_count(iter_count), .timeout_err(timeout_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model of the host's architectural state
    logic [X_FLAT_W-1:0] exp_x;
    logic [P_FLAT_W-1:0] exp_p;
    logic [15:0]         exp_iter;
    logic                exp_err;
    logic [31:0]         exp_q[$];   // estimate words still owed, in order
    int                  hs_count = 0;
    int                  total_hs = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [X_FLAT_W-1:0] rand_x();
        logic [X_FLAT_W-1:0] v;
        for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [P_FLAT_W-1:0] rand_p();
        logic [P_FLAT_W-1:0] v;
        for (int i = 0; i < 36; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Output-stream monitor: order, index, last flag and hold-while-stalled.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [2:0]  prev_idx;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("est_hold_data", 192'(est_data), 192'(prev_data));
                chk("est_hold_idx", 192'(est_idx), 192'(prev_idx));
            end
            if (est_valid && est_ready) begin
                total_hs++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL est_unexpected: got word %h idx %0d expected no word", est_data, est_idx);
                end else begin
                    chk("est_data", 192'(est_data), 192'(exp_q.pop_front()));
                    chk("est_idx", 192'(est_idx), 192'(hs_count));
                    chk("est_last", 192'(est_last), 192'(hs_count == NS - 1));
                    hs_count = (hs_count == NS - 1) ? 0 : hs_count + 1;
                end
            end
            prev_stall = est_valid && !est_ready;
            prev_data  = est_data;
            prev_idx   = est_idx;
        end
    end

    // Sends one iteration's measurements with random valid gaps; all checks come
    // from the count rule (0 or >4 means 4) and the packing rule.
    task automatic send_meas(input logic [2:0] sz, output logic [Z_FLAT_W-1:0] z_exp);
        int n, sent, guard;
        logic [31:0] w;
        n = (sz == 3'd0 || sz > 3'd4) ? 4 : int'(sz);
        z_exp = '0;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < 64) begin
            w          = $urandom;
            meas_valid = ($urandom_range(0, 2) != 0);
            meas_data  = w;
            size_meas  = (sent == 0) ? sz : 3'($urandom_range(0, 7));
            #1 chk("meas_ready_collect", 192'(meas_ready), 192'(1));
            if (meas_valid) begin
                z_exp[sent*32 +: 32] = w;
                sent++;
            end
            step();
            chk("busy_collect", 192'(busy), 192'(sent == n));
            chk("kf_start_pulse", 192'(kf_start), 192'(sent == n));
            guard++;
        end
        meas_valid = 1'b0;
        chk("z_flat", 192'(z_flat), 192'(z_exp));
    endtask

    // Called right after kf_start is seen; done is sampled delay+1 edges later.
    task automatic respond(input int delay, input logic [X_FLAT_W-1:0] x, input logic [P_FLAT_W-1:0] p);
        for (int i = 0; i < delay; i++) begin
            meas_valid = ($urandom_range(0, 1) == 1);
            meas_data  = $urandom;
            init       = ($urandom_range(0, 7) == 0);
            x0_flat    = rand_x();
            step();
        end
        meas_valid = 1'b0;
        init       = 1'b0;
        kf_x_out   = x;
        kf_P_out   = p;
        kf_done    = 1'b1;
        step();
        kf_done  = 1'b0;
        kf_x_out = rand_x();
        kf_P_out = rand_p();
    endtask

    task automatic drain();
        int guard = 0;
        while (est_valid && guard < 200) begin
            est_ready = ($urandom_range(0, 1) == 1);
            step();
            guard++;
        end
        est_ready = 1'b0;
        chk("est_drained", 192'(est_valid), 192'(0));
        chk("est_q_empty", 192'(exp_q.size()), 192'(0));
        chk("busy_after_emit", 192'(busy), 192'(0));
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_x_flat"}, x_flat, exp_x);
        chk({tag, "_P_flat"}, 192'(P_flat === exp_p), 192'(1));
        chk({tag, "_iter"}, 192'(iter_count), 192'(exp_iter));
        chk({tag, "_err"}, 192'(timeout_err), 192'(exp_err));
    endtask

    typedef struct {
        logic        init;
        logic        mv;
        logic [31:0] data;
        logic [2:0]  size;
        logic        ready;
        logic        busy;
        logic        start;
        logic [63:0] z;
    } vec_t;

    vec_t                tv[5];
    logic [Z_FLAT_W-1:0] zexp;
    logic [X_FLAT_W-1:0] xn;
    logic [P_FLAT_W-1:0] pn;
    logic                stall_pat[9];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; init = 1'b0; meas_valid = 1'b0; meas_data = '0; size_meas = '0;
        kf_done = 1'b0; kf_x_out = '0; kf_P_out = '0; est_ready = 1'b0;
        x0_flat = rand_x(); P0_flat = rand_p();
        x0_flat[31:0] = 32'h0000_1000;
        repeat (3) step();
        rst = 1'b0;
        exp_x = '0; exp_p = '0; exp_iter = '0; exp_err = 1'b0;
        chk("reset_meas_ready", 192'(meas_ready), 192'(1));
        chk("reset_busy", 192'(busy), 192'(0));
        chk("reset_z", 192'(z_flat), 192'(0));
        chk("reset_kf_start", 192'(kf_start), 192'(0));
        chk("reset_est_valid", 192'(est_valid), 192'(0));
        check_state("reset");

        // init + same-cycle word, then two words with size 2
        tv[0] = '{1'b1, 1'b1, 32'hDEAD_0000, 3'd2, 1'b0, 1'b0, 1'b0, 64'h0};
        tv[1] = '{1'b0, 1'b1, 32'h0000_2000, 3'd2, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_2000};
        tv[2] = '{1'b0, 1'b0, 32'hBEEF_0000, 3'd0, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_2000};
        tv[3] = '{1'b0, 1'b1, 32'h0000_3000, 3'd0, 1'b1, 1'b1, 1'b1, 64'h0000_3000_0000_2000};
        tv[4] = '{1'b0, 1'b1, 32'h7777_7777, 3'd1, 1'b0, 1'b1, 1'b0, 64'h0000_3000_0000_2000};
        for (int i = 0; i < 5; i++) begin
            init = tv[i].init; meas_valid = tv[i].mv; meas_data = tv[i].data; size_meas = tv[i].size;
            #1 chk($sformatf("vec%0d_meas_ready", i), 192'(meas_ready), 192'(tv[i].ready));
            step();
            chk($sformatf("vec%0d_busy", i), 192'(busy), 192'(tv[i].busy));
            chk($sformatf("vec%0d_kf_start", i), 192'(kf_start), 192'(tv[i].start));
            chk($sformatf("vec%0d_z_lo", i), 192'(z_flat[63:0]), 192'(tv[i].z));
        end
        init = 1'b0; meas_valid = 1'b0;
        exp_x = x0_flat; exp_p = P0_flat;
        chk("z_hi_zero", 192'(z_flat[127:64]), 192'(0));
        check_state("after_init");

        // filter answers 10 cycles after start with words 0x1000..0x6000
        for (int i = 0; i < 6; i++) xn[i*32 +: 32] = 32'h1000 * (i + 1);
        pn = rand_p();
        for (int i = 0; i < 6; i++) exp_q.push_back(xn[i*32 +: 32]);
        respond(9, xn, pn);
        exp_x = xn; exp_p = pn; exp_iter = 16'd1;
        check_state("first_update");
        chk("first_est_valid", 192'(est_valid), 192'(1));
        chk("first_est_idx", 192'(est_idx), 192'(0));
        chk("first_est_data", 192'(est_data), 192'(32'h1000));
        step();
        stall_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) begin
            est_ready = stall_pat[i];
            if (!stall_pat[i]) begin
                chk("stall_data", 192'(est_data), 192'(32'h3000));
                chk("stall_idx", 192'(est_idx), 192'(2));
            end
            step();
        end
        est_ready = 1'b0;
        chk("burst_done_valid", 192'(est_valid), 192'(0));
        chk("burst_handshakes", 192'(total_hs), 192'(6));
        chk("burst_meas_ready", 192'(meas_ready), 192'(1));

        // watchdog: no kf_done
        send_meas(3'd1, zexp);
        repeat (16) step();
        chk("wd_not_yet", 192'(timeout_err), 192'(0));
        chk("wd_busy", 192'(busy), 192'(1));
        step();
        exp_err = 1'b1;
        check_state("timeout");
        chk("timeout_busy", 192'(busy), 192'(0));
        chk("timeout_meas_ready", 192'(meas_ready), 192'(1));

        init = 1'b1; x0_flat = rand_x(); P0_flat = rand_p();
        step();
        init = 1'b0;
        exp_x = x0_flat; exp_p = P0_flat; exp_iter = '0; exp_err = 1'b0;
        check_state("reinit");
        chk("reinit_z", 192'(z_flat), 192'(0));

        // size 0 means 4 words; kf_done on the timeout cycle wins
        send_meas(3'd0, zexp);
        xn = rand_x(); pn = rand_p();
        for (int i = 0; i < 6; i++) exp_q.push_back(xn[i*32 +: 32]);
        respond(16, xn, pn);
        exp_x = xn; exp_p = pn; exp_iter++;
        check_state("done_at_timeout");
        chk("done_at_timeout_est_valid", 192'(est_valid), 192'(1));
        drain();

        // randomized iterations
        for (int it = 0; it < 24; it++) begin
            send_meas(3'($urandom_range(0, 7)), zexp);
            if ($urandom_range(0, 4) == 0) begin
                for (int c = 0; c < 16; c++) begin
                    meas_valid = ($urandom_range(0, 1) == 1);
                    init = ($urandom_range(0, 7) == 0);
                    step();
                end
                meas_valid = 1'b0; init = 1'b0;
                chk("rnd_wd_busy", 192'(busy), 192'(1));
                step();
                exp_err = 1'b1;
                check_state("rnd_timeout");
            end else begin
                xn = rand_x(); pn = rand_p();
                for (int i = 0; i < 6; i++) exp_q.push_back(xn[i*32 +: 32]);
                respond($urandom_range(1, 16), xn, pn);
                exp_x = xn; exp_p = pn; exp_iter++;
                check_state("rnd_update");
                chk("rnd_est_valid", 192'(est_valid), 192'(1));
                drain();
            end
            if ($urandom_range(0, 5) == 0) begin
                init = 1'b1; meas_valid = 1'b1; meas_data = $urandom;
                x0_flat = rand_x(); P0_flat = rand_p();
                step();
                init = 1'b0; meas_valid = 1'b0;
                exp_x = x0_flat; exp_p = P0_flat; exp_iter = '0; exp_err = 1'b0;
                check_state("rnd_init");
                chk("rnd_init_z", 192'(z_flat), 192'(0));
            end
        end

        // reset mid-iteration
        send_meas(3'd2, zexp);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_x = '0; exp_p = '0; exp_iter = '0; exp_err = 1'b0;
        hs_count = 0;
        check_state("mid_reset");
        chk("mid_reset_busy", 192'(busy), 192'(0));
        chk("mid_reset_meas_ready", 192'(meas_ready), 192'(1));
        chk("mid_reset_z", 192'(z_flat), 192'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
